// File: rtl/bsmac_pkg.sv
// Shared types and helpers for the bit-serial MAC array.
// State encodings, derived widths and output saturation.
package bsmac_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_FETCH = 3'd1;
   localparam state_t S_LATCH = 3'd2;
   localparam state_t S_BITS  = 3'd3;
   localparam state_t S_DRAIN = 3'd4;
   localparam state_t S_DONE  = 3'd5;

   function automatic int clog1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int acc_w(input int dw, input int nin);
      return 2 * dw + $clog2(nin) + 1;
   endfunction

   function automatic int ngrp(input int nh, input int p);
      return (nh + p - 1) / p;
   endfunction

   function automatic int aw(input int nh, input int p, input int nin);
      return clog1(ngrp(nh, p) * nin);
   endfunction

   function automatic logic signed [63:0] sat_relu(
      input logic signed [63:0] v,
      input int                 out_w,
      input logic               relu
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] t;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      t  = (relu && v < 0) ? 64'sd0 : v;
      if (t > hi) return hi;
      if (t < lo) return lo;
      return t;
   endfunction

endpackage

// File: rtl/bsmac_out_if.sv
// Result stream: one saturated neuron value plus its index.
// valid/ready handshake, transfer when both are high.
interface bsmac_out_if #(
   parameter int OUT_W = 16,
   parameter int IDX_W = 6
);
   logic signed [OUT_W-1:0] out_data;
   logic [IDX_W-1:0]        out_idx;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output out_data, out_idx, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_idx, out_valid,
      output out_ready
   );
endinterface

// File: rtl/bsmac_lane.sv
// One neuron lane: holds the weight word and the accumulator.
// Bit k of the weight gates the shifted activation; the top bit subtracts.
module bsmac_lane #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int BIAS_W = 32,
   parameter int KW     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_bias,
   input  logic signed [BIAS_W-1:0] i_bias,
   input  logic                     cap_w,
   input  logic [DATA_W-1:0]        i_w,
   input  logic                     bit_en,
   input  logic                     last_bit,
   input  logic [KW-1:0]            i_k,
   input  logic signed [ACC_W-1:0]  i_addend,
   output logic signed [ACC_W-1:0]  o_acc
);

   logic [DATA_W-1:0]       r_w;
   logic signed [ACC_W-1:0] r_acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_w   <= '0;
         r_acc <= '0;
      end else begin
         if (cap_w)
            r_w <= i_w;
         if (load_bias)
            r_acc <= ACC_W'(i_bias);
         else if (bit_en && r_w[i_k])
            r_acc <= last_bit ? r_acc - i_addend
                              : r_acc + i_addend;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/bitserial_mac_array.sv
// Bit-serial matrix-vector engine: P neurons per group, run-time
// weight precision, saturated/ReLU results streamed with backpressure.
module bitserial_mac_array
   import bsmac_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int N_IN     = 128,
   parameter int N_HIDDEN = 64,
   parameter int P        = 4,
   parameter int BIAS_W   = 32,
   parameter int OUT_W    = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             abort,
   input  logic [$clog2(DATA_W):0]          cfg_prec,
   input  logic                             cfg_relu,
   input  logic [N_IN*DATA_W-1:0]           invec_bus,
   input  logic [N_HIDDEN*BIAS_W-1:0]       bias_bus,
   output logic [aw(N_HIDDEN,P,N_IN)-1:0]   wmem_raddr,
   input  logic [P*DATA_W-1:0]              wmem_rdata,
   bsmac_out_if.master                      o_out,
   output logic                             busy,
   output logic                             done
);

   localparam int ACC_W = acc_w(DATA_W, N_IN);
   localparam int NGRP  = ngrp(N_HIDDEN, P);
   localparam int AW    = aw(N_HIDDEN, P, N_IN);
   localparam int PW    = $clog2(DATA_W) + 1;
   localparam int KW    = $clog2(DATA_W);
   localparam int IW    = clog1(N_IN);
   localparam int GW    = clog1(NGRP);
   localparam int LW    = clog1(P);
   localparam int HW    = clog1(N_HIDDEN);
   localparam int NPAD  = (1 << GW) * P;

   state_t                   r_state;
   logic [PW-1:0]            r_prec;
   logic                     r_relu;
   logic [GW-1:0]            r_grp;
   logic [IW-1:0]            r_i;
   logic [KW-1:0]            r_k;
   logic [LW-1:0]            r_lane;
   logic [AW-1:0]            r_raddr;
   logic signed [DATA_W-1:0] r_a;

   logic [PW-1:0]            w_prec;
   logic                     w_start;
   logic                     w_last_bit;
   logic                     w_last_in;
   logic                     w_last_lane;
   logic                     w_last_grp;
   logic                     w_xfer;
   logic                     w_next_grp;
   logic                     w_load;
   logic                     w_valid;
   int                       w_h;
   logic [GW-1:0]            w_bgrp;
   logic [NPAD*BIAS_W-1:0]   w_bias_pad;
   logic signed [ACC_W-1:0]  w_addend;
   logic signed [ACC_W-1:0]  w_acc [P];

   always_comb begin
      w_prec = cfg_prec;
      if (cfg_prec == '0)
         w_prec = PW'(1);
      else if (cfg_prec > PW'(DATA_W))
         w_prec = PW'(DATA_W);
   end

   always_comb begin
      w_bias_pad = '0;
      w_bias_pad[N_HIDDEN*BIAS_W-1:0] = bias_bus;
   end

   assign w_start     = (r_state == S_IDLE) && start && !abort;
   assign w_last_bit  = ({1'b0, r_k} == r_prec - 1'b1);
   assign w_last_in   = (r_i == IW'(N_IN - 1));
   assign w_h         = int'(r_grp) * P + int'(r_lane);
   assign w_last_lane = (int'(r_lane) == P - 1) || (w_h + 1 >= N_HIDDEN);
   assign w_last_grp  = (int'(r_grp) == NGRP - 1);
   assign w_valid     = (r_state == S_DRAIN);
   assign w_xfer      = w_valid && o_out.out_ready;
   assign w_next_grp  = w_xfer && w_last_lane && !w_last_grp && !abort;
   assign w_load      = w_start || w_next_grp;
   assign w_addend    = ACC_W'(r_a) <<< r_k;
   // Bias is loaded for the group about to start, not the current one.
   assign w_bgrp      = (r_state == S_IDLE) ? '0 : r_grp + 1'b1;

   for (genvar l = 0; l < P; l++) begin : g_lane
      bsmac_lane #(
         .DATA_W(DATA_W),
         .ACC_W (ACC_W),
         .BIAS_W(BIAS_W),
         .KW    (KW)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_bias(w_load),
         .i_bias   (w_bias_pad[(int'(w_bgrp)*P+l)*BIAS_W +: BIAS_W]),
         .cap_w    (r_state == S_LATCH),
         .i_w      (wmem_rdata[l*DATA_W +: DATA_W]),
         .bit_en   (r_state == S_BITS),
         .last_bit (w_last_bit),
         .i_k      (r_k),
         .i_addend (w_addend),
         .o_acc    (w_acc[l])
      );
   end

   // Address is set on entry to FETCH so read data is valid in LATCH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_prec  <= PW'(1);
         r_relu  <= 1'b0;
         r_grp   <= '0;
         r_i     <= '0;
         r_k     <= '0;
         r_lane  <= '0;
         r_raddr <= '0;
         r_a     <= '0;
      end else if (abort) begin
         r_state <= S_IDLE;
         r_raddr <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: if (start) begin
               r_prec  <= w_prec;
               r_relu  <= cfg_relu;
               r_grp   <= '0;
               r_i     <= '0;
               r_raddr <= '0;
               r_state <= S_FETCH;
            end
            S_FETCH: r_state <= S_LATCH;
            S_LATCH: begin
               r_a     <= invec_bus[int'(r_i)*DATA_W +: DATA_W];
               r_k     <= '0;
               r_state <= S_BITS;
            end
            S_BITS: if (!w_last_bit) begin
               r_k <= r_k + 1'b1;
            end else if (w_last_in) begin
               r_lane  <= '0;
               r_state <= S_DRAIN;
            end else begin
               r_i     <= r_i + 1'b1;
               r_raddr <= r_raddr + 1'b1;
               r_state <= S_FETCH;
            end
            S_DRAIN: if (w_xfer) begin
               if (!w_last_lane) begin
                  r_lane <= r_lane + 1'b1;
               end else if (!w_last_grp) begin
                  r_grp   <= r_grp + 1'b1;
                  r_i     <= '0;
                  r_raddr <= r_raddr + 1'b1;
                  r_state <= S_FETCH;
               end else begin
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wmem_raddr      = r_raddr;
   assign o_out.out_valid = w_valid;
   assign o_out.out_idx   = w_valid ? HW'(w_h) : '0;
   assign o_out.out_data  = w_valid
      ? OUT_W'(sat_relu(64'(w_acc[r_lane]), OUT_W, r_relu)) : '0;
   assign busy            = (r_state != S_IDLE);
   assign done            = (r_state == S_DONE);

endmodule
